// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: register-file widths, the FSM
// state encoding and the long-latency result entry held in the buffer.
package wb_arb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } ll_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Small circular buffer of long-latency results; occupancy is exported so the
// arbiter can see one cycle ahead when the buffer is about to fill.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  ll_entry_t push_entry,
    input  logic      pop,
    output ll_entry_t head,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count
);

    ll_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline and buffered
// mul/div results. Optional same-cycle LL bypass: define WB_ARB_BYPASS_EN.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DEPTH        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteEnD,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic [XLEN-1:0]       ResultD,
    input  logic                  LL_Valid,
    input  logic [REG_ADDR_W-1:0] LL_Rd,
    input  logic [XLEN-1:0]       LL_Data,
    output logic                  LL_Ready,
    output logic                  RF_WE,
    output logic [REG_ADDR_W-1:0] RF_Rd,
    output logic [XLEN-1:0]       RF_WD,
    output logic                  StallW,
    output logic                  LL_Pending
);

    localparam int CW = $clog2(DEPTH) + 1;

    arb_state_e            state_q, state_d;
    logic [3:0]            starve_q, starve_d, starve_inc;
    logic                  pipe_act, ll_fire, ll_keep, bypass;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;
    ll_entry_t             head, push_entry;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
    logic                  stall;

    assign pipe_act   = RegWriteEnD && (RdD != '0);
    assign LL_Ready   = rst && !fifo_full;
    assign ll_fire    = LL_Valid && LL_Ready;
    assign ll_keep    = ll_fire && (LL_Rd != '0);
    assign push_entry = '{rd: LL_Rd, data: LL_Data};

`ifdef WB_ARB_BYPASS_EN
    assign bypass = ll_keep && fifo_empty && (state_q == NORMAL) && !pipe_act;
`else
    assign bypass = 1'b0;
`endif
    assign push = ll_keep && !bypass;

    wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        starve_inc = starve_q + 4'd1;
        pop        = 1'b0;
        we         = 1'b0;
        rd         = '0;
        wd         = '0;
        stall      = 1'b0;
        case (state_q)
            NORMAL: begin
                if (pipe_act) begin
                    we = 1'b1;
                    rd = RdD;
                    wd = ResultD;
                    if (!fifo_empty) begin
                        starve_d = starve_inc;
                        if (starve_inc >= 4'(STARVE_LIMIT)) state_d = FORCE;
                    end
                    // The push landing now fills the buffer while it is being passed over.
                    if (push && (fifo_count == CW'(DEPTH - 1))) state_d = FORCE;
                end else if (!fifo_empty) begin
                    we       = 1'b1;
                    rd       = head.rd;
                    wd       = head.data;
                    pop      = 1'b1;
                    starve_d = '0;
                end else if (bypass) begin
                    we = 1'b1;
                    rd = LL_Rd;
                    wd = LL_Data;
                end
            end
            FORCE: begin
                if (!fifo_empty) begin
                    we  = 1'b1;
                    rd  = head.rd;
                    wd  = head.data;
                    pop = 1'b1;
                end
                stall    = pipe_act;
                starve_d = '0;
                state_d  = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
        if (fifo_empty) starve_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Outputs are forced quiet for as long as reset is held.
    assign RF_WE      = rst && we;
    assign RF_Rd      = rst ? rd : '0;
    assign RF_WD      = rst ? wd : '0;
    assign StallW     = rst && stall;
    assign LL_Pending = rst && !fifo_empty;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table plus hand-written
// multi-cycle sequences, with a write scoreboard on the register-file port.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteEnD;
    logic [4:0]  RdD;
    logic [31:0] ResultD;
    logic        LL_Valid;
    logic [4:0]  LL_Rd;
    logic [31:0] LL_Data;
    logic        LL_Ready;
    logic        RF_WE;
    logic [4:0]  RF_Rd;
    logic [31:0] RF_WD;
    logic        StallW;
    logic        LL_Pending;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        llv;
        logic [4:0]  llrd;
        logic [31:0] lld;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_wd;
        logic        e_ready;
        logic        e_pend;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(4), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteEnD (RegWriteEnD),
        .RdD         (RdD),
        .ResultD     (ResultD),
        .LL_Valid    (LL_Valid),
        .LL_Rd       (LL_Rd),
        .LL_Data     (LL_Data),
        .LL_Ready    (LL_Ready),
        .RF_WE       (RF_WE),
        .RF_Rd       (RF_Rd),
        .RF_WD       (RF_WD),
        .StallW      (StallW),
        .LL_Pending  (LL_Pending)
    );

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    // Inputs change 1ns after the rising edge; checks land 4ns after it.
    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic llv, input logic [4:0] llrd, input logic [31:0] lld);
        @(posedge clk);
        #1;
        RegWriteEnD = we;
        RdD         = rd;
        ResultD     = res;
        LL_Valid    = llv;
        LL_Rd       = llrd;
        LL_Data     = lld;
        #3;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Scoreboard: every register-file write must match the oldest expectation.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst === 1'b1 && RF_WE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", RF_Rd, RF_WD);
            end else begin
                e = exp_q.pop_front();
                chk("sb_write", 40'({RF_Rd, RF_WD}), 40'({e.rd, e.data}));
            end
        end
    end

    initial begin
        vt[0] = '{1'b1, 5'd10, 32'hAABBCCDD, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hAABBCCDD, 1'b1, 1'b0};
        vt[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vt[2] = '{1'b0, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
        vt[3] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0};
        vt[4] = '{1'b0, 5'd0,  32'h0, 1'b1, 5'd0, 32'h00000123, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0};
        vt[5] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd0, 32'h456, 1'b1, 5'd1, 32'h00000001, 1'b1, 1'b0};
        vt[6] = '{1'b0, 5'd0,  32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,               1'b1, 1'b0};

        // Reset held with both requesters active: everything must stay quiet.
        rst = 1'b0;
        RegWriteEnD = 1'b1; RdD = 5'd10; ResultD = 32'hAABBCCDD;
        LL_Valid = 1'b1; LL_Rd = 5'd3; LL_Data = 32'h5;
        #12;
        chk("reset_rf", 40'({RF_WE, RF_Rd, RF_WD}), 40'h0);
        chk("reset_ctl", 40'({LL_Ready, StallW, LL_Pending}), 40'h0);
        @(posedge clk);
        #1;
        RegWriteEnD = 1'b0; RdD = '0; ResultD = '0; LL_Valid = 1'b0; LL_Rd = '0; LL_Data = '0;
        rst = 1'b1;
        #3;
        chk("release_ready", 40'({LL_Ready, LL_Pending}), 40'b10);

        for (int i = 0; i < 7; i++) begin
            drive(vt[i].we, vt[i].rd, vt[i].res, vt[i].llv, vt[i].llrd, vt[i].lld);
            if (vt[i].e_we) expect_wr(vt[i].e_rd, vt[i].e_wd);
            chk($sformatf("vec%0d_rf", i), 40'({RF_WE, RF_Rd, RF_WD}),
                40'({vt[i].e_we, vt[i].e_rd, vt[i].e_wd}));
            chk($sformatf("vec%0d_ctl", i), 40'({StallW, LL_Ready, LL_Pending}),
                40'({1'b0, vt[i].e_ready, vt[i].e_pend}));
        end

        // Single LL result with the pipeline idle.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h11223344);
`ifdef WB_ARB_BYPASS_EN
        expect_wr(5'd5, 32'h11223344);
        chk("ll_bypass", 40'({RF_WE, RF_Rd, RF_WD}), 40'({1'b1, 5'd5, 32'h11223344}));
        idle();
        chk("ll_done", 40'({RF_WE, LL_Pending}), 40'h0);
`else
        chk("ll_not_early", 40'({RF_WE, LL_Pending}), 40'h0);
        idle();
        expect_wr(5'd5, 32'h11223344);
        chk("ll_next_cycle", 40'({RF_WE, RF_Rd, RF_WD}), 40'({1'b1, 5'd5, 32'h11223344}));
        idle();
        chk("ll_done", 40'({RF_WE, RF_Rd, RF_WD, LL_Pending}), 40'h0);
`endif

        // Starvation: one entry to x7 under continuous pipeline writes.
        drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h77);
        expect_wr(5'd1, 32'h100);
        chk("starve_push", 40'({RF_WE, RF_Rd, StallW, LL_Pending}), 40'({1'b1, 5'd1, 1'b0, 1'b0}));
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd1, 32'h100 + 32'(k), 1'b0, 5'd0, 32'h0);
            expect_wr(5'd1, 32'h100 + 32'(k));
            chk($sformatf("starve_grant%0d", k), 40'({RF_WE, RF_Rd, StallW, LL_Pending}),
                40'({1'b1, 5'd1, 1'b0, 1'b1}));
        end
        drive(1'b1, 5'd1, 32'h104, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd7, 32'h77);
        chk("starve_force", 40'({RF_WE, RF_Rd, StallW}), 40'({1'b1, 5'd7, 1'b1}));
        drive(1'b1, 5'd1, 32'h104, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd1, 32'h104);
        chk("starve_resume", 40'({RF_WE, RF_Rd, StallW, LL_Pending}), 40'({1'b1, 5'd1, 1'b0, 1'b0}));
        idle();

        // Buffer fills while the pipeline holds the port.
        drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd8, 32'h88);
        expect_wr(5'd2, 32'h200);
        chk("full_push1", 40'({LL_Ready, LL_Pending}), 40'b10);
        drive(1'b1, 5'd2, 32'h201, 1'b1, 5'd9, 32'h99);
        expect_wr(5'd2, 32'h201);
        chk("full_push2", 40'({LL_Ready, LL_Pending}), 40'b11);
        drive(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd8, 32'h88);
        chk("full_force", 40'({LL_Ready, StallW, RF_WE, RF_Rd}), 40'({1'b0, 1'b1, 1'b1, 5'd8}));
        drive(1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd2, 32'h202);
        chk("full_after_pop", 40'({LL_Ready, StallW, LL_Pending, RF_Rd}), 40'({1'b1, 1'b0, 1'b1, 5'd2}));
        idle();
        expect_wr(5'd9, 32'h99);
        chk("full_drain", 40'({RF_WE, RF_Rd}), 40'({1'b1, 5'd9}));
        idle();
        chk("full_empty", 40'({LL_Pending, RF_WE}), 40'h0);

        // Reset with two entries buffered and the FSM in FORCE.
        drive(1'b1, 5'd3, 32'h300, 1'b1, 5'd11, 32'hB1);
        expect_wr(5'd3, 32'h300);
        drive(1'b1, 5'd3, 32'h301, 1'b1, 5'd12, 32'hB2);
        expect_wr(5'd3, 32'h301);
        @(posedge clk);
        #1;
        rst = 1'b0;
        RegWriteEnD = 1'b0; RdD = '0; ResultD = '0; LL_Valid = 1'b0; LL_Rd = '0; LL_Data = '0;
        #3;
        chk("midrst_rf", 40'({RF_WE, RF_Rd, RF_WD}), 40'h0);
        chk("midrst_ctl", 40'({LL_Ready, StallW, LL_Pending}), 40'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #3;
        chk("midrst_release", 40'({LL_Ready, LL_Pending, StallW, RF_WE}), 40'b1000);
        drive(1'b1, 5'd4, 32'h400, 1'b0, 5'd0, 32'h0);
        expect_wr(5'd4, 32'h400);
        chk("midrst_normal", 40'({RF_WE, RF_Rd, StallW, LL_Pending}), 40'({1'b1, 5'd4, 1'b0, 1'b0}));
        idle();
        chk("midrst_quiet", 40'({RF_WE, LL_Pending}), 40'h0);
        idle();

        chk("sb_drained", 40'(exp_q.size()), 40'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
